// File: rtl/cnn_pkg.sv
// Shared types and constants for the feature-map RAM readers.
package cnn_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } rd_state_t;

    localparam int RD_FIFO_DEPTH = 4;

    // Address width for an n-entry dimension; never narrower than one bit.
    function automatic int addr_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/stream_fifo.sv
// Small synchronous FIFO with show-ahead head; pop and push may share a cycle.
module stream_fifo #(
    parameter int DWIDTH = 34,
    parameter int DEPTH  = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_push,
    input  logic [DWIDTH-1:0] i_data,
    input  logic              i_pop,
    output logic [DWIDTH-1:0] o_data,
    output logic              o_valid
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [DWIDTH-1:0] r_mem [DEPTH];
    logic [PW-1:0]     r_wr_ptr;
    logic [PW-1:0]     r_rd_ptr;
    logic [CW-1:0]     r_count;
    logic              w_pop;
    logic              w_push;

    assign w_pop   = i_pop && (r_count != '0);
    assign w_push  = i_push && ((r_count != CW'(DEPTH)) || w_pop);
    assign o_valid = (r_count != '0);
    assign o_data  = r_mem[r_rd_ptr];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= i_data;
                r_wr_ptr <= (r_wr_ptr == PW'(DEPTH - 1)) ? '0 : r_wr_ptr + PW'(1);
            end
            if (w_pop)
                r_rd_ptr <= (r_rd_ptr == PW'(DEPTH - 1)) ? '0 : r_rd_ptr + PW'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/ram_2d_reader.sv
// Raster-scans a window of the feature-map RAM and streams the words out
// with end-of-row / end-of-window tags, throttled by a read credit.
module ram_2d_reader
    import cnn_pkg::*;
#(
    parameter int DWIDTH = 32,
    parameter int HEIGHT = 8,
    parameter int WIDTH  = 8,
    parameter int AW_H   = addr_width(HEIGHT),
    parameter int AW_W   = addr_width(WIDTH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [AW_H-1:0]   row0,
    input  logic [AW_W-1:0]   col0,
    input  logic [AW_H:0]     rows,
    input  logic [AW_W:0]     cols,
    output logic              busy,
    output logic              done,
    output logic              ram_rw,
    output logic [AW_H-1:0]   ram_haddr,
    output logic [AW_W-1:0]   ram_waddr,
    input  logic [DWIDTH-1:0] ram_dataout,
    output logic [DWIDTH-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_eol,
    output logic              out_eof
);

    localparam int CW = $clog2(RD_FIFO_DEPTH + 1);

    rd_state_t       r_state;
    logic            r_busy;
    logic            r_done;
    logic [AW_H-1:0] r_haddr;
    logic [AW_W-1:0] r_waddr;
    logic [AW_W-1:0] r_col0;
    logic [AW_H:0]   r_rows;
    logic [AW_W:0]   r_cols;
    logic [AW_H:0]   r_row_idx;
    logic [AW_W:0]   r_col_idx;
    logic            r_last;
    logic [CW-1:0]   r_credit;
    logic            r_s1_vld, r_s1_eol, r_s1_eof;
    logic            r_s2_vld, r_s2_eol, r_s2_eof;

    logic              w_row_end;
    logic [AW_W:0]     w_nxt_col;
    logic [AW_H:0]     w_nxt_row;
    logic              w_nxt_eol;
    logic              w_nxt_eof;
    logic              w_pop;
    logic              w_can_issue;
    logic              w_start_ok;
    logic              w_issue;
    logic [DWIDTH+1:0] w_fifo_q;

    always_comb begin
        w_row_end   = (r_col_idx == r_cols - 1'b1);
        w_nxt_col   = w_row_end ? '0 : r_col_idx + 1'b1;
        w_nxt_row   = w_row_end ? r_row_idx + 1'b1 : r_row_idx;
        w_nxt_eol   = (w_nxt_col == r_cols - 1'b1);
        w_nxt_eof   = w_nxt_eol && (w_nxt_row == r_rows - 1'b1);
        w_pop       = out_valid && out_ready;
        w_can_issue = (r_credit < CW'(RD_FIFO_DEPTH));
        w_start_ok  = start && (r_state == IDLE) && (rows != '0) && (cols != '0);
        w_issue     = w_start_ok || ((r_state == RUN) && !r_last && w_can_issue);
    end

    // Credit covers stage 1, stage 2 and the FIFO, so the FIFO cannot overflow.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state   <= IDLE;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_haddr   <= '0;
            r_waddr   <= '0;
            r_col0    <= '0;
            r_rows    <= '0;
            r_cols    <= '0;
            r_row_idx <= '0;
            r_col_idx <= '0;
            r_last    <= 1'b0;
            r_credit  <= '0;
            r_s1_vld  <= 1'b0;
            r_s1_eol  <= 1'b0;
            r_s1_eof  <= 1'b0;
            r_s2_vld  <= 1'b0;
            r_s2_eol  <= 1'b0;
            r_s2_eof  <= 1'b0;
        end else begin
            r_done   <= 1'b0;
            r_credit <= r_credit + CW'(w_issue) - CW'(w_pop);
            r_s1_vld <= w_issue;
            r_s2_vld <= r_s1_vld;
            r_s2_eol <= r_s1_eol;
            r_s2_eof <= r_s1_eof;
            case (r_state)
                IDLE: begin
                    if (w_start_ok) begin
                        r_state   <= RUN;
                        r_busy    <= 1'b1;
                        r_haddr   <= row0;
                        r_waddr   <= col0;
                        r_col0    <= col0;
                        r_rows    <= rows;
                        r_cols    <= cols;
                        r_row_idx <= '0;
                        r_col_idx <= '0;
                        r_s1_eol  <= (cols == (AW_W+1)'(1));
                        r_s1_eof  <= (cols == (AW_W+1)'(1)) && (rows == (AW_H+1)'(1));
                        r_last    <= (cols == (AW_W+1)'(1)) && (rows == (AW_H+1)'(1));
                    end else if (start) begin
                        r_done <= 1'b1;
                    end
                end
                RUN: begin
                    if (r_last) begin
                        r_state <= DRAIN;
                    end else if (w_can_issue) begin
                        r_col_idx <= w_nxt_col;
                        r_row_idx <= w_nxt_row;
                        r_waddr   <= w_row_end ? r_col0 : r_waddr + 1'b1;
                        r_haddr   <= w_row_end ? r_haddr + 1'b1 : r_haddr;
                        r_s1_eol  <= w_nxt_eol;
                        r_s1_eof  <= w_nxt_eof;
                        r_last    <= w_nxt_eof;
                    end
                end
                DRAIN: begin
                    if (w_pop && out_eof) begin
                        r_state <= IDLE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_last  <= 1'b0;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    stream_fifo #(
        .DWIDTH(DWIDTH + 2),
        .DEPTH (RD_FIFO_DEPTH)
    ) u_fifo (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_push (r_s2_vld),
        .i_data ({r_s2_eof, r_s2_eol, ram_dataout}),
        .i_pop  (out_ready),
        .o_data (w_fifo_q),
        .o_valid(out_valid)
    );

    assign ram_rw    = 1'b1;
    assign ram_haddr = r_haddr;
    assign ram_waddr = r_waddr;
    assign busy      = r_busy;
    assign done      = r_done;
    assign out_data  = w_fifo_q[DWIDTH-1:0];
    assign out_eol   = w_fifo_q[DWIDTH];
    assign out_eof   = w_fifo_q[DWIDTH+1];

endmodule

// File: tb/tb_ram_2d_reader.sv
// Bench for ram_2d_reader: RAM model holds h*16+w, beats are scoreboarded.
module tb_ram_2d_reader;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [2:0]  row0 = '0;
    logic [2:0]  col0 = '0;
    logic [3:0]  rows = '0;
    logic [3:0]  cols = '0;
    logic        busy, done, ram_rw;
    logic [2:0]  ram_haddr, ram_waddr;
    logic [31:0] ram_dataout = '0;
    logic [31:0] out_data;
    logic        out_valid, out_eol, out_eof;
    logic        out_ready = 1'b1;

    int          total = 0;
    int          bad = 0;
    int          beats = 0;
    logic [33:0] exp_q[$];
    logic        hold_v = 1'b0;
    logic [33:0] hold_w = '0;

    ram_2d_reader #(.DWIDTH(32), .HEIGHT(8), .WIDTH(8)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .row0       (row0),
        .col0       (col0),
        .rows       (rows),
        .cols       (cols),
        .busy       (busy),
        .done       (done),
        .ram_rw     (ram_rw),
        .ram_haddr  (ram_haddr),
        .ram_waddr  (ram_waddr),
        .ram_dataout(ram_dataout),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_eol    (out_eol),
        .out_eof    (out_eof)
    );

    always #5 clk = ~clk;

    // Registered-read RAM preloaded with ram[h][w] = h*16+w.
    always @(posedge clk)
        ram_dataout <= {25'b0, ram_haddr, 4'h0} + {29'b0, ram_waddr};

    task automatic push_window(input int r0, input int c0, input int nr, input int nc);
        for (int r = 0; r < nr; r++)
            for (int c = 0; c < nc; c++) begin
                int h = (r0 + r) % 8;
                int w = (c0 + c) % 8;
                exp_q.push_back({(c == nc - 1) && (r == nr - 1), (c == nc - 1), 32'(h * 16 + w)});
            end
    endtask

    // Negedge sample: scoreboard pop on handshake, stability while stalled.
    task automatic sample();
        logic [33:0] w;
        @(negedge clk);
        if (!rst_n) begin
            hold_v = 1'b0;
        end else begin
            if (hold_v) begin
                total++;
                if (!out_valid || {out_eof, out_eol, out_data} !== hold_w) begin
                    bad++;
                    $display("FAIL stall_stable: got v=%0b %h want %h", out_valid,
                             {out_eof, out_eol, out_data}, hold_w);
                end
            end
            if (out_valid && out_ready) begin
                beats++;
                total++;
                if (exp_q.size() == 0) begin
                    bad++;
                    $display("FAIL unexpected_beat: got %h want none", {out_eof, out_eol, out_data});
                end else begin
                    w = exp_q.pop_front();
                    if ({out_eof, out_eol, out_data} !== w) begin
                        bad++;
                        $display("FAIL beat: got eof/eol/data %h want %h", {out_eof, out_eol, out_data}, w);
                    end
                end
            end
            hold_v = out_valid && !out_ready;
            hold_w = {out_eof, out_eol, out_data};
        end
    endtask

    // Leaves the bench at the negedge of c1.
    task automatic do_start(input int r0, input int c0, input int nr, input int nc, input bit push);
        if (push) push_window(r0, c0, nr, nc);
        @(posedge clk); #1;
        start = 1'b1; row0 = 3'(r0); col0 = 3'(c0); rows = 4'(nr); cols = 4'(nc);
        sample();
        @(posedge clk); #1;
        start = 1'b0;
        sample();
    endtask

    task automatic wait_done(input int c_now, input int exp_c, input string nm);
        int  c = c_now;
        bit  found = 1'b0;
        while (!found && c < c_now + 400) begin
            @(posedge clk); #1;
            sample();
            c++;
            if (done) found = 1'b1;
        end
        total++;
        if (!found || c != exp_c) begin
            bad++;
            $display("FAIL %s_done: got found=%0b cycle=%0d want cycle=%0d", nm, found, c, exp_c);
        end
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL %s_left: got %0d beats missing want 0", nm, exp_q.size());
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) begin @(posedge clk); #1; sample(); end
        total++;
        if (ram_rw !== 1'b1) begin bad++; $display("FAIL rst_ram_rw: got %b want 1", ram_rw); end
        total++;
        if ({busy, done, out_valid, out_eol, out_eof} !== 5'b0) begin
            bad++; $display("FAIL rst_flags: got %b want 00000", {busy, done, out_valid, out_eol, out_eof});
        end
        total++;
        if (out_data !== 32'h0 || ram_haddr !== 3'h0 || ram_waddr !== 3'h0) begin
            bad++; $display("FAIL rst_values: got data=%h h=%0d w=%0d want 0", out_data, ram_haddr, ram_waddr);
        end
        @(posedge clk); #1; rst_n = 1'b1; sample();
        @(posedge clk); #1; sample();
        total++;
        if (busy !== 1'b0 || out_valid !== 1'b0 || ram_rw !== 1'b1) begin
            bad++; $display("FAIL idle_after_rst: got busy=%b valid=%b rw=%b want 0 0 1", busy, out_valid, ram_rw);
        end
    endtask

    task automatic test_basic();
        beats = 0;
        do_start(1, 2, 2, 3, 1'b1);
        total++;
        if (ram_haddr !== 3'd1 || ram_waddr !== 3'd2 || busy !== 1'b1) begin
            bad++; $display("FAIL basic_c1: got h=%0d w=%0d busy=%b want 1 2 1", ram_haddr, ram_waddr, busy);
        end
        for (int k = 2; k <= 9; k++) begin
            @(posedge clk); #1;
            sample();
            total++;
            if (out_valid !== ((k >= 3) && (k <= 8))) begin
                bad++; $display("FAIL basic_valid_c%0d: got %b want %b", k, out_valid, (k >= 3) && (k <= 8));
            end
            total++;
            if (done !== (k == 9)) begin
                bad++; $display("FAIL basic_done_c%0d: got %b want %b", k, done, k == 9);
            end
        end
        total++;
        if (beats != 6 || exp_q.size() != 0) begin
            bad++; $display("FAIL basic_count: got beats=%0d left=%0d want 6 0", beats, exp_q.size());
        end
    endtask

    task automatic test_full();
        bit          pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
        logic [2:0]  ph, pw;
        int          issues, max_out, b0;
        bit          fin = 1'b0;
        beats = 0;
        ph = ram_haddr;
        pw = ram_waddr;
        do_start(0, 0, 8, 8, 1'b1);
        issues = (ram_haddr !== ph || ram_waddr !== pw) ? 1 : 0;
        max_out = issues;
        ph = ram_haddr;
        pw = ram_waddr;
        for (int k = 0; k < 600 && !fin; k++) begin
            @(posedge clk); #1;
            out_ready = pat[k % 4];
            b0 = beats;
            sample();
            if (ram_haddr !== ph || ram_waddr !== pw) issues++;
            ph = ram_haddr;
            pw = ram_waddr;
            if (issues - b0 > max_out) max_out = issues - b0;
            if (done) fin = 1'b1;
        end
        @(posedge clk); #1; out_ready = 1'b1; sample();
        total++;
        if (!fin) begin bad++; $display("FAIL full_done: got timeout want done"); end
        total++;
        if (beats != 64 || exp_q.size() != 0) begin
            bad++; $display("FAIL full_count: got beats=%0d left=%0d want 64 0", beats, exp_q.size());
        end
        total++;
        if (max_out > 4) begin bad++; $display("FAIL full_credit: got %0d outstanding want <=4", max_out); end
    endtask

    task automatic test_wrap();
        beats = 0;
        do_start(6, 7, 3, 2, 1'b1);
        wait_done(1, 9, "wrap");
    endtask

    task automatic test_zero();
        int nr [2] = '{0, 3};
        int nc [2] = '{5, 0};
        for (int i = 0; i < 2; i++) begin
            bit seen = 1'b0;
            do_start(2, 3, nr[i], nc[i], 1'b0);
            total++;
            if (done !== 1'b1 || busy !== 1'b0) begin
                bad++; $display("FAIL zero%0d_c1: got done=%b busy=%b want 1 0", i, done, busy);
            end
            repeat (5) begin
                @(posedge clk); #1;
                sample();
                if (busy || out_valid || done) seen = 1'b1;
            end
            total++;
            if (seen) begin bad++; $display("FAIL zero%0d_quiet: got activity want none", i); end
        end
    endtask

    task automatic test_restart();
        beats = 0;
        do_start(0, 0, 2, 4, 1'b1);
        @(posedge clk); #1; sample();
        @(posedge clk); #1;
        start = 1'b1; row0 = 3'd5; col0 = 3'd5; rows = 4'd3; cols = 4'd3;
        sample();
        @(posedge clk); #1; start = 1'b0; sample();
        wait_done(4, 11, "restart");
        total++;
        if (beats != 8) begin bad++; $display("FAIL restart_count: got %0d want 8", beats); end
    endtask

    task automatic test_reset_mid();
        out_ready = 1'b0;
        do_start(0, 0, 8, 8, 1'b1);
        repeat (3) begin @(posedge clk); #1; sample(); end
        @(posedge clk); #1;
        rst_n = 1'b0;
        sample();
        total++;
        if (out_valid !== 1'b1 || busy !== 1'b1) begin
            bad++; $display("FAIL mid_queued: got valid=%b busy=%b want 1 1", out_valid, busy);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        out_ready = 1'b1;
        sample();
        total++;
        if ({out_valid, busy, done} !== 3'b000) begin
            bad++; $display("FAIL mid_reset: got valid/busy/done=%b want 000", {out_valid, busy, done});
        end
        exp_q.delete();
        beats = 0;
        do_start(1, 2, 2, 3, 1'b1);
        @(posedge clk); #1; sample();
        total++;
        if (out_valid !== 1'b0) begin bad++; $display("FAIL mid_c2_valid: got %b want 0", out_valid); end
        @(posedge clk); #1; sample();
        total++;
        if (out_valid !== 1'b1) begin bad++; $display("FAIL mid_c3_valid: got %b want 1", out_valid); end
        wait_done(3, 9, "mid");
        total++;
        if (beats != 6) begin bad++; $display("FAIL mid_count: got %0d want 6", beats); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_full();
        test_wrap();
        test_zero();
        test_restart();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
